wn_pdcchrx_angle_rep_arbiter: RTL and testbench
===============================================

WN_PDCCHRX_ANGLE_REP_ARBITER -- requirements
Module: wn_pdcchrx_angle_rep_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing one angle repeater (2..4).
REQ-002 SHALL have parameter TAG_DEPTH, default 4, owner-tag FIFO depth (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req_cfg_tdata/tvalid/tready  in/in/out  NREQ*9/NREQ/NREQ  per-requester repeater config word (bit8 flag, bits7:2 count, bits1:0 mode).
REQ-006 SHALL have ports req_data_tdata/tvalid/tready/tlast  in/in/out/in  NREQ*48/NREQ/NREQ/NREQ  per-requester IQ stream, imag 47:24, real 23:0.
REQ-007 SHALL have ports rep_cfg_tdata/tvalid/tready  out/out/in  9/1/1  config to the repeater.
REQ-008 SHALL have ports rep_din_tdata/tvalid/tready/tlast  out/out/in/out  48/1/1/1  data to the repeater.
REQ-009 SHALL have ports rep_dout_tdata/tvalid/tready/tlast  in/in/out/in  48/1/1/1  repeater output.
REQ-010 SHALL have ports out_tdata/tvalid/tready/tlast/tdest  out/out/in/out/out  48/1/1/1/$clog2(NREQ)  merged output tagged with owner.

Function
REQ-011 SHALL run FSM IDLE -> CFG -> DATA -> IDLE; one granted packet = one config word plus one data burst ending in tlast.
REQ-012 SHALL in IDLE, when any req_cfg_tvalid is high and the tag FIFO is not full, register a grant to the first requesting index at or after rr_ptr (round-robin, wrapping), then enter CFG.
REQ-013 SHALL in CFG pass the granted requester's config to rep_cfg combinationally (valid, data, ready muxed); on handshake push the grant index into the tag FIFO and enter DATA.
REQ-014 SHALL in DATA pass the granted requester's data stream to rep_din combinationally; on handshake with tlast=1 return to IDLE and set rr_ptr = grant+1 mod NREQ.
REQ-015 SHALL hold all non-granted req_cfg_tready and req_data_tready low, and rep_cfg_tvalid low outside CFG, rep_din_tvalid low outside DATA.
REQ-016 SHALL drive out_* from rep_dout_* with out_tdest = tag FIFO head; rep_dout_tready = out_tready AND FIFO not empty; out_tvalid = rep_dout_tvalid AND FIFO not empty.
REQ-017 SHALL pop the tag FIFO on out handshake with tlast=1.
REQ-018 SHALL handle simultaneous push and pop in one cycle with occupancy unchanged, including when full (no push is possible when full since grant is blocked).
REQ-019 SHALL accept a single-beat burst (tlast on first beat): CFG->DATA->IDLE in minimum 3 cycles per packet.
REQ-020 SHALL ignore req_data_tvalid of a requester until it holds a grant in DATA; data arriving before config is stalled, not dropped.
REQ-021 SHALL treat out_tdata widths unchanged: 24-bit real/imag, no arithmetic.

Reset
REQ-022 SHALL on rstn low: state IDLE, rr_ptr 0, grant 0, tag FIFO empty, all tvalid/tready outputs 0, out_tdest 0, stat counters 0.
REQ-023 SHALL on reset asserted mid-packet abandon the packet; after release restart from IDLE with no residual tags.

Configuration
REQ-024 SHALL with macro WN_ANGLE_ARB_STATS_EN defined add output stat_pkt_cnt (NREQ*16) counting completed input packets per requester, wrapping at 16'hFFFF->0, and output stat_stall_cnt (16) counting IDLE cycles with a request pending but tag FIFO full, saturating.
REQ-025 SHALL without WN_ANGLE_ARB_STATS_EN omit both ports and counters entirely.

Structure
REQ-026 SHALL place in package wn_pdcchrx_pkg: FSM state enum, config-word field widths (9/6/2/1), IQ width 24.
REQ-027 SHALL implement the owner-tag FIFO as sub-module wn_pdcchrx_tag_fifo (sync, count-based full/empty).

Verification
REQ-028 SHALL cover: req0 only, cfg 9'h105, 4-beat burst -> rep_cfg 9'h105 once, 4 rep_din beats, output tdest=0, rr_ptr=1.
REQ-029 SHALL cover: req0 and req1 both valid at reset release -> grant order 0,1,0,1 over 4 packets; tdest sequence matches.
REQ-030 SHALL cover: out_tready held 0, TAG_DEPTH=4 -> exactly 4 configs forwarded, 5th held until first output tlast accepted.
REQ-031 SHALL cover: 1-beat bursts back-to-back -> one packet per 3 cycles, no beat lost, tlast preserved.
REQ-032 SHALL cover: rstn pulsed low during beat 2 of 8 -> all valids 0 next cycle, FIFO empty, next packet completes correctly.
REQ-033 SHALL cover (STATS_EN): 3 packets req1, 2 req0 -> stat_pkt_cnt = {16'd3,16'd2}; forced full FIFO 10 cycles -> stat_stall_cnt=10.

Source files
------------

// File: rtl/wn_pdcchrx_pkg.sv
// wn_pdcchrx_pkg: shared FSM state, config-word field widths and IQ widths for the angle repeater arbiter
package wn_pdcchrx_pkg;
  typedef enum logic [1:0] {IDLE, CFG, DATA} arb_state_t;
  localparam int CFG_W = 9;
  localparam int CNT_W = 6;
  localparam int MODE_W = 2;
  localparam int FLAG_W = 1;
  localparam int IQ_W = 24;
  localparam int BEAT_W = 2 * IQ_W;
endpackage

// File: rtl/wn_pdcchrx_tag_fifo.sv
// wn_pdcchrx_tag_fifo: synchronous owner-tag FIFO with count-based full/empty
module wn_pdcchrx_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end
endmodule

// File: rtl/wn_pdcchrx_angle_rep_arbiter.sv
// wn_pdcchrx_angle_rep_arbiter: round-robin sharing of one angle repeater among NREQ requesters, output tagged with owner
// Optional per-requester packet and stall statistics with WN_ANGLE_ARB_STATS_EN
module wn_pdcchrx_angle_rep_arbiter
  import wn_pdcchrx_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ*CFG_W-1:0]     req_cfg_tdata,
  input  logic [NREQ-1:0]           req_cfg_tvalid,
  output logic [NREQ-1:0]           req_cfg_tready,
  input  logic [NREQ*BEAT_W-1:0]    req_data_tdata,
  input  logic [NREQ-1:0]           req_data_tvalid,
  output logic [NREQ-1:0]           req_data_tready,
  input  logic [NREQ-1:0]           req_data_tlast,
  output logic [CFG_W-1:0]          rep_cfg_tdata,
  output logic                      rep_cfg_tvalid,
  input  logic                      rep_cfg_tready,
  output logic [BEAT_W-1:0]         rep_din_tdata,
  output logic                      rep_din_tvalid,
  input  logic                      rep_din_tready,
  output logic                      rep_din_tlast,
  input  logic [BEAT_W-1:0]         rep_dout_tdata,
  input  logic                      rep_dout_tvalid,
  output logic                      rep_dout_tready,
  input  logic                      rep_dout_tlast,
  output logic [BEAT_W-1:0]         out_tdata,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic                      out_tlast,
  output logic [$clog2(NREQ)-1:0]   out_tdest
`ifdef WN_ANGLE_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]        stat_pkt_cnt,
  output logic [15:0]               stat_stall_cnt
`endif
);
  localparam int IW = $clog2(NREQ);
  arb_state_t state, state_nx;
  logic [IW-1:0] rr_ptr, grant, pick, idx;
  logic [CFG_W-1:0] cfg_arr [NREQ];
  logic [BEAT_W-1:0] data_arr [NREQ];
  logic start, push, done, pop, full, empty;
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cfg_arr[g] = req_cfg_tdata[g*CFG_W +: CFG_W];
    assign data_arr[g] = req_data_tdata[g*BEAT_W +: BEAT_W];
  end
  // descending scan so the requester closest to rr_ptr is the last (winning) write
  always_comb begin
    pick = rr_ptr;
    idx = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % NREQ);
      if (req_cfg_tvalid[idx]) pick = idx;
    end
  end
  assign start = state == IDLE && |req_cfg_tvalid && !full;
  assign push = state == CFG && req_cfg_tvalid[grant] && rep_cfg_tready;
  assign done = state == DATA && req_data_tvalid[grant] && rep_din_tready && req_data_tlast[grant];
  always_comb begin
    req_cfg_tready = '0;
    req_data_tready = '0;
    req_cfg_tready[grant] = state == CFG && rep_cfg_tready;
    req_data_tready[grant] = state == DATA && rep_din_tready;
    rep_cfg_tvalid = state == CFG && req_cfg_tvalid[grant];
    rep_din_tvalid = state == DATA && req_data_tvalid[grant];
    rep_cfg_tdata = cfg_arr[grant];
    rep_din_tdata = data_arr[grant];
    rep_din_tlast = req_data_tlast[grant];
    state_nx = state == IDLE ? (start ? CFG : IDLE) :
               state == CFG  ? (push ? DATA : CFG) :
               state == DATA ? (done ? IDLE : DATA) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
    end else begin
      state <= state_nx;
      if (start) grant <= pick;
      if (done) rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end
  end
  assign out_tvalid = rep_dout_tvalid && !empty;
  assign rep_dout_tready = out_tready && !empty;
  assign out_tdata = rep_dout_tdata;
  assign out_tlast = rep_dout_tlast;
  assign pop = out_tvalid && out_tready && rep_dout_tlast;
  wn_pdcchrx_tag_fifo #(.DEPTH(TAG_DEPTH), .W(IW)) u_tag_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(push),
    .din(grant),
    .pop(pop),
    .dout(out_tdest),
    .full(full),
    .empty(empty)
  );
`ifdef WN_ANGLE_ARB_STATS_EN
  logic [15:0] pkt_cnt [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_pkt_cnt[g*16 +: 16] = pkt_cnt[g];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) pkt_cnt[i] <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (done) pkt_cnt[grant] <= pkt_cnt[grant] + 16'd1;
      if (state == IDLE && |req_cfg_tvalid && full && stat_stall_cnt != 16'hFFFF)
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wn_pdcchrx_angle_rep_arbiter.sv
// tb_wn_pdcchrx_angle_rep_arbiter: directed scenarios against a packet-level round-robin model with a queue-based repeater stand-in
module tb_wn_pdcchrx_angle_rep_arbiter;
  localparam int NREQ = 2;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic [NREQ*9-1:0] req_cfg_tdata;
  logic [NREQ-1:0] req_cfg_tvalid, req_cfg_tready;
  logic [NREQ*48-1:0] req_data_tdata;
  logic [NREQ-1:0] req_data_tvalid, req_data_tready, req_data_tlast;
  logic [8:0] rep_cfg_tdata;
  logic rep_cfg_tvalid, rep_cfg_tready;
  logic [47:0] rep_din_tdata, rep_dout_tdata, out_tdata;
  logic rep_din_tvalid, rep_din_tready, rep_din_tlast;
  logic rep_dout_tvalid, rep_dout_tready, rep_dout_tlast;
  logic out_tvalid, out_tready, out_tlast;
  logic [0:0] out_tdest;
`ifdef WN_ANGLE_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_pkt_cnt;
  logic [15:0] stat_stall_cnt;
`endif
  wn_pdcchrx_angle_rep_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rstn(rstn),
    .req_cfg_tdata(req_cfg_tdata), .req_cfg_tvalid(req_cfg_tvalid), .req_cfg_tready(req_cfg_tready),
    .req_data_tdata(req_data_tdata), .req_data_tvalid(req_data_tvalid), .req_data_tready(req_data_tready),
    .req_data_tlast(req_data_tlast),
    .rep_cfg_tdata(rep_cfg_tdata), .rep_cfg_tvalid(rep_cfg_tvalid), .rep_cfg_tready(rep_cfg_tready),
    .rep_din_tdata(rep_din_tdata), .rep_din_tvalid(rep_din_tvalid), .rep_din_tready(rep_din_tready),
    .rep_din_tlast(rep_din_tlast),
    .rep_dout_tdata(rep_dout_tdata), .rep_dout_tvalid(rep_dout_tvalid), .rep_dout_tready(rep_dout_tready),
    .rep_dout_tlast(rep_dout_tlast),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_tdest(out_tdest)
`ifdef WN_ANGLE_ARB_STATS_EN
    , .stat_pkt_cnt(stat_pkt_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );
  int npk[NREQ], cfg_idx[NREQ], dpk[NREQ], dbeat[NREQ], planned[NREQ];
  logic [8:0] pcfg[NREQ][32];
  int plen[NREQ][32];
  logic [48:0] rq[$];
  logic [8:0] exp_cfg[$];
  logic [48:0] exp_din[$];
  logic [49:0] exp_out[$];
  int cfg_cyc[$], last_cyc[$], dest_seq[$];
  logic [8:0] cfg_seen[$];
  int rr_m, cyc, n_chk, n_fail, n_cfg, n_din;
  logic [8:0] last_cfg;
  bit din_bp, ot;
  function automatic logic [47:0] beat(int r, int p, int b);
    return {8'(r), 8'(p), 8'(b), 24'h5A5A5A};
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic fail(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_cfg_tvalid[i] = cfg_idx[i] < npk[i];
      req_cfg_tdata[i*9 +: 9] = pcfg[i][cfg_idx[i]];
      req_data_tvalid[i] = dpk[i] < npk[i];
      req_data_tdata[i*48 +: 48] = beat(i, dpk[i], dbeat[i]);
      req_data_tlast[i] = dbeat[i] == plen[i][dpk[i]] - 1;
    end
    rep_cfg_tready = din_bp ? (cyc % 2 == 0) : 1'b1;
    rep_din_tready = din_bp ? (cyc % 3 != 0) : 1'b1;
    rep_dout_tvalid = rq.size() > 0;
    {rep_dout_tlast, rep_dout_tdata} = rq.size() > 0 ? rq[0] : 49'h0;
    out_tready = ot;
  endtask
  task automatic load(int r, logic [8:0] c, int len);
    pcfg[r][npk[r]] = c;
    plen[r][npk[r]] = len;
    npk[r]++;
    drive();
  endtask
  // packet-level round robin over every requester with packets not yet planned
  task automatic plan();
    bit any;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (rr_m + k) % NREQ;
        if (!any && planned[i] < npk[i]) begin
          any = 1'b1;
          exp_cfg.push_back(pcfg[i][planned[i]]);
          for (int b = 0; b < plen[i][planned[i]]; b++) begin
            exp_din.push_back({b == plen[i][planned[i]] - 1, beat(i, planned[i], b)});
            exp_out.push_back({1'(i), b == plen[i][planned[i]] - 1, beat(i, planned[i], b)});
          end
          planned[i]++;
          rr_m = (i + 1) % NREQ;
        end
      end
    end
  endtask
  task automatic step();
    logic [NREQ-1:0] ca, da;
    bit dh, oh;
    logic [48:0] dv;
    @(negedge clk);
    cyc++;
    chk("exclusive", (($countones(req_cfg_tready) + $countones(req_data_tready)) <= 1) && !(rep_cfg_tvalid && rep_din_tvalid), 1);
    ca = req_cfg_tvalid & req_cfg_tready;
    da = req_data_tvalid & req_data_tready;
    dh = rep_din_tvalid && rep_din_tready;
    oh = out_tvalid && out_tready;
    dv = {rep_din_tlast, rep_din_tdata};
    if (rep_cfg_tvalid && rep_cfg_tready) begin
      n_cfg++;
      cfg_cyc.push_back(cyc);
      cfg_seen.push_back(rep_cfg_tdata);
      last_cfg = rep_cfg_tdata;
      if (exp_cfg.size() == 0) fail("rep_cfg_unexpected");
      else chk("rep_cfg", rep_cfg_tdata, exp_cfg.pop_front());
    end
    if (dh) begin
      n_din++;
      if (exp_din.size() == 0) fail("rep_din_unexpected");
      else chk("rep_din", dv, exp_din.pop_front());
    end
    if (oh) begin
      if (exp_out.size() == 0) fail("out_unexpected");
      else chk("out_beat", {out_tdest, out_tlast, out_tdata}, exp_out.pop_front());
      if (out_tlast) begin
        last_cyc.push_back(cyc);
        dest_seq.push_back(int'(out_tdest));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ca[i]) cfg_idx[i]++;
      if (da[i]) begin
        if (dbeat[i] == plen[i][dpk[i]] - 1) begin
          dpk[i]++;
          dbeat[i] = 0;
        end else dbeat[i]++;
      end
    end
    if (oh) void'(rq.pop_front());
    if (dh) rq.push_back(dv);
    drive();
  endtask
  task automatic run_idle(int budget);
    int n;
    n = 0;
    while ((exp_out.size() + exp_cfg.size() + exp_din.size()) > 0 && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail("drain_timeout");
    repeat (2) step();
  endtask
  task automatic reset_begin();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("reset_outputs", {rep_cfg_tvalid, rep_din_tvalid, out_tvalid, rep_dout_tready,
        req_cfg_tready, req_data_tready, out_tdest}, 0);
    for (int i = 0; i < NREQ; i++) begin
      npk[i] = 0; cfg_idx[i] = 0; dpk[i] = 0; dbeat[i] = 0; planned[i] = 0;
    end
    rq.delete(); exp_cfg.delete(); exp_din.delete(); exp_out.delete();
    rr_m = 0;
    drive();
  endtask
  task automatic reset_end();
    repeat (2) @(negedge clk);
    chk("reset_hold", {rep_cfg_tvalid, rep_din_tvalid, out_tvalid, req_cfg_tready, req_data_tready}, 0);
    rstn = 1'b1;
    dest_seq.delete(); cfg_cyc.delete(); last_cyc.delete(); cfg_seen.delete();
    n_cfg = 0;
    n_din = 0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int base, lb, n;
    int seq029[4];
    seq029 = '{0, 1, 0, 1};
    ot = 1'b1;
    din_bp = 1'b0;
    drive();
    reset_begin();
    reset_end();
    load(0, 9'h105, 4);
    plan();
    run_idle(200);
    chk("s028_cfg_count", n_cfg, 1);
    chk("s028_cfg_word", last_cfg, 9'h105);
    chk("s028_din_beats", n_din, 4);
    chk("s028_pkts_out", dest_seq.size(), 1);
    if (dest_seq.size() > 0) chk("s028_tdest", dest_seq[0], 0);
    load(0, 9'h011, 1);
    load(1, 9'h1F2, 2);
    plan();
    run_idle(200);
    chk("rr_cfg_count", cfg_seen.size(), 3);
    if (cfg_seen.size() > 2) begin
      chk("rr_req1_first", cfg_seen[1], 9'h1F2);
      chk("rr_req0_second", cfg_seen[2], 9'h011);
    end
    reset_begin();
    load(0, 9'h0A1, 3);
    load(0, 9'h0A2, 1);
    load(1, 9'h1B1, 2);
    load(1, 9'h1B2, 4);
    plan();
    din_bp = 1'b1;
    reset_end();
    run_idle(400);
    din_bp = 1'b0;
    chk("s029_pkts", dest_seq.size(), 4);
    for (int k = 0; k < 4 && k < dest_seq.size(); k++) chk("s029_tdest_seq", dest_seq[k], seq029[k]);
    base = n_cfg;
    for (int k = 0; k < 4; k++) load(1, 9'h0C0 + 9'(k), 1);
    plan();
    run_idle(200);
    chk("s031_cfg_count", n_cfg - base, 4);
    for (int k = 1; k < 4 && base + k < cfg_cyc.size(); k++) chk("s031_gap", cfg_cyc[base+k] - cfg_cyc[base+k-1], 3);
    ot = 1'b0;
    base = n_cfg;
    lb = last_cyc.size();
    for (int k = 0; k < 6; k++) load(0, 9'h0D0 + 9'(k), 2);
    plan();
    repeat (40) step();
    chk("s030_held_cfgs", n_cfg - base, 4);
    chk("s030_cfg_blocked", rep_cfg_tvalid, 0);
    ot = 1'b1;
    run_idle(400);
    chk("s030_total_cfgs", n_cfg - base, 6);
    if (cfg_cyc.size() > base + 4 && last_cyc.size() > lb)
      chk("s030_fifth_after_pop", cfg_cyc[base+4] > last_cyc[lb], 1);
    else fail("s030_missing_events");
    ot = 1'b0;
    base = n_din;
    load(0, 9'h0E8, 8);
    plan();
    n = 0;
    while (n_din - base < 1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail("s032_beat_timeout");
    reset_begin();
    ot = 1'b1;
    reset_end();
    load(1, 9'h1E3, 3);
    plan();
    run_idle(200);
    chk("s032_cfg_word", last_cfg, 9'h1E3);
    chk("s032_din_beats", n_din, 3);
    chk("s032_pkts", dest_seq.size(), 1);
    if (dest_seq.size() > 0) chk("s032_tdest", dest_seq[0], 1);
    chk("all_expected_seen", exp_out.size() + exp_cfg.size() + exp_din.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
